// File: rtl/bp_me_nonsynth_trace_replay.sv
// Trace replay driver for one mock-LCE port: walks a combinational trace ROM,
// issues packets over valid/yumi and checks returned packets over valid/ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for en_i
// EXEC  | decode rom_data_i[3:0] at pc; stalls while en_i is low
// SEND  | present payload with tr_pkt_v_o until tr_pkt_yumi_i
// RECV  | tr_pkt_ready_o high until tr_pkt_v_i or timeout
// WAIT  | count down the loaded cycle count, then advance pc
// DONE  | terminal, done_o high, handshakes low until reset
module bp_me_nonsynth_trace_replay
  #(parameter int tr_ring_width_p   = 0
   ,parameter int rom_addr_width_p  = 10
   ,parameter int timeout_p         = 4096
   ,localparam int rom_data_width_lp = 4 + tr_ring_width_p
   )
  (input  logic                          clk_i
  ,input  logic                          reset_n_i
  ,input  logic                          en_i
  ,output logic [rom_addr_width_p-1:0]   rom_addr_o
  ,input  logic [rom_data_width_lp-1:0]  rom_data_i
  ,output logic                          tr_pkt_v_o
  ,output logic [tr_ring_width_p-1:0]    tr_pkt_o
  ,input  logic                          tr_pkt_yumi_i
  ,input  logic                          tr_pkt_v_i
  ,input  logic [tr_ring_width_p-1:0]    tr_pkt_i
  ,output logic                          tr_pkt_ready_o
  ,output logic                          done_o
  ,output logic                          error_o
  ,output logic [15:0]                   mismatch_cnt_o
  );

  localparam int to_width_lp = $clog2(timeout_p + 1);
  localparam logic [to_width_lp-1:0] to_last_lp = to_width_lp'(timeout_p - 1);

  typedef enum logic [2:0] {
    e_idle, e_exec, e_send, e_recv, e_wait, e_done
  } state_e;

  typedef enum logic [3:0] {
    e_op_nop    = 4'd0,
    e_op_send   = 4'd1,
    e_op_recv   = 4'd2,
    e_op_wait   = 4'd3,
    e_op_finish = 4'd4
  } opcode_e;

  state_e                        state_r, state_n;
  logic [rom_addr_width_p-1:0]   pc_r, pc_n;
  logic [15:0]                   wait_cnt_r, wait_cnt_n;
  logic [to_width_lp-1:0]        to_cnt_r, to_cnt_n;
  logic                          error_r, error_n;
  logic [15:0]                   mismatch_cnt_r, mismatch_cnt_n;
  logic                          advance;

  logic [3:0]                    opcode;
  logic [tr_ring_width_p-1:0]    payload;

  assign opcode  = rom_data_i[3:0];
  assign payload = rom_data_i[rom_data_width_lp-1:4];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r        <= e_idle;
      pc_r           <= '0;
      wait_cnt_r     <= '0;
      to_cnt_r       <= '0;
      error_r        <= 1'b0;
      mismatch_cnt_r <= '0;
    end
    else begin
      state_r        <= state_n;
      pc_r           <= pc_n;
      wait_cnt_r     <= wait_cnt_n;
      to_cnt_r       <= to_cnt_n;
      error_r        <= error_n;
      mismatch_cnt_r <= mismatch_cnt_n;
    end
  end

  always_comb begin
    state_n        = state_r;
    pc_n           = pc_r;
    wait_cnt_n     = wait_cnt_r;
    to_cnt_n       = to_cnt_r;
    error_n        = error_r;
    mismatch_cnt_n = mismatch_cnt_r;
    advance        = 1'b0;
    tr_pkt_v_o     = 1'b0;
    tr_pkt_o       = '0;
    tr_pkt_ready_o = 1'b0;

    unique case (state_r)
      e_idle: begin
        if (en_i)
          state_n = e_exec;
      end

      e_exec: begin
        if (en_i) begin
          case (opcode)
            e_op_nop:    advance = 1'b1;
            e_op_send:   state_n = e_send;
            e_op_recv: begin
              to_cnt_n = '0;
              state_n  = e_recv;
            end
            e_op_wait: begin
              wait_cnt_n = 16'(payload);
              state_n    = e_wait;
            end
            e_op_finish: state_n = e_done;
            default: begin
              error_n = 1'b1;
              state_n = e_done;
            end
          endcase
        end
      end

      e_send: begin
        // pc is held, so the ROM word and tr_pkt_o stay stable until yumi
        tr_pkt_v_o = 1'b1;
        tr_pkt_o   = payload;
        if (tr_pkt_yumi_i)
          advance = 1'b1;
      end

      e_recv: begin
        tr_pkt_ready_o = 1'b1;
        if (tr_pkt_v_i) begin
          if (tr_pkt_i != payload) begin
            error_n = 1'b1;
            if (mismatch_cnt_r != 16'hFFFF)
              mismatch_cnt_n = mismatch_cnt_r + 16'd1;
          end
          advance = 1'b1;
        end
        else if (to_cnt_r == to_last_lp) begin
          error_n = 1'b1;
          state_n = e_done;
        end
        else begin
          to_cnt_n = to_cnt_r + 1'b1;
        end
      end

      e_wait: begin
        if (wait_cnt_r == 16'd0)
          advance = 1'b1;
        else
          wait_cnt_n = wait_cnt_r - 16'd1;
      end

      e_done: ;

      default: state_n = e_idle;
    endcase

    // Running off the end of the ROM is an error rather than a wrap to 0
    if (advance) begin
      if (&pc_r) begin
        error_n = 1'b1;
        state_n = e_done;
      end
      else begin
        pc_n    = pc_r + 1'b1;
        state_n = e_exec;
      end
    end
  end

  assign rom_addr_o     = pc_r;
  assign done_o         = (state_r == e_done);
  assign error_o        = error_r;
  assign mismatch_cnt_o = mismatch_cnt_r;

endmodule

// File: tb/tb_bp_me_nonsynth_trace_replay.sv
// Bench for bp_me_nonsynth_trace_replay: traces are interpreted by a cycle-cost
// model in the bench, and the DUT's packets, flags and done time are compared to it.
module tb_bp_me_nonsynth_trace_replay;

  localparam int trw_lp   = 40;
  localparam int aw_lp    = 4;
  localparam int to_lp    = 16;
  localparam int rom_n_lp = 16;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  en;
  logic [aw_lp-1:0]      rom_addr;
  logic [trw_lp+3:0]     rom_data;
  logic                  v_o;
  logic [trw_lp-1:0]     pkt_o;
  logic                  yumi;
  logic                  v_i;
  logic [trw_lp-1:0]     pkt_i;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic [15:0]           mis;

  logic [trw_lp+3:0]     rom [rom_n_lp];

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  bp_me_nonsynth_trace_replay #(
    .tr_ring_width_p (trw_lp),
    .rom_addr_width_p(aw_lp),
    .timeout_p       (to_lp)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .en_i          (en),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .tr_pkt_v_o    (v_o),
    .tr_pkt_o      (pkt_o),
    .tr_pkt_yumi_i (yumi),
    .tr_pkt_v_i    (v_i),
    .tr_pkt_i      (pkt_i),
    .tr_pkt_ready_o(ready),
    .done_o        (done),
    .error_o       (err),
    .mismatch_cnt_o(mis)
  );

  int checks = 0;
  int errors = 0;

  // trace description: opcode, payload, handshake delay, value the bench returns, no-response flag
  int                op_code [rom_n_lp];
  logic [trw_lp-1:0] op_pay  [rom_n_lp];
  int                op_dly  [rom_n_lp];
  logic [trw_lp-1:0] op_ret  [rom_n_lp];
  bit                op_nr   [rom_n_lp];

  logic [trw_lp-1:0] exp_send[$];
  int                exp_send_dly[$];
  logic [trw_lp-1:0] exp_recv_val[$];
  int                exp_recv_dly[$];
  bit                exp_recv_nr[$];
  int  exp_done_t, exp_mis, exp_pc, exp_vcyc, exp_recv_acks;
  bit  exp_err;

  function automatic logic [trw_lp-1:0] rand_pay();
    return trw_lp'({$urandom, $urandom});
  endfunction

  task automatic clear_trace();
    for (int i = 0; i < rom_n_lp; i++) begin
      op_code[i] = 4;
      op_pay[i]  = '0;
      op_dly[i]  = 0;
      op_ret[i]  = '0;
      op_nr[i]   = 1'b0;
    end
  endtask

  task automatic set_op(input int i, input int code, input logic [trw_lp-1:0] pay,
                        input int dly, input logic [trw_lp-1:0] ret, input bit nr);
    op_code[i] = code;
    op_pay[i]  = pay;
    op_dly[i]  = dly;
    op_ret[i]  = ret;
    op_nr[i]   = nr;
  endtask

  task automatic load_rom();
    for (int i = 0; i < rom_n_lp; i++)
      rom[i] = {op_pay[i], 4'(op_code[i])};
  endtask

  // Interpret the trace: each op has a fixed cycle cost given the bench's delays.
  // t counts clock edges after reset release; the first EXEC is seen at t=1.
  task automatic build_expect();
    int pc = 0;
    int t  = 1;
    bit fin = 1'b0;
    bit adv;
    exp_send.delete(); exp_send_dly.delete();
    exp_recv_val.delete(); exp_recv_dly.delete(); exp_recv_nr.delete();
    exp_err = 1'b0; exp_mis = 0; exp_vcyc = 0; exp_recv_acks = 0;
    while (!fin) begin
      adv = 1'b0;
      case (op_code[pc])
        0: begin t += 1; adv = 1'b1; end
        1: begin
          t += 2 + op_dly[pc];
          exp_send.push_back(op_pay[pc]);
          exp_send_dly.push_back(op_dly[pc]);
          exp_vcyc += op_dly[pc] + 1;
          adv = 1'b1;
        end
        2: begin
          exp_recv_val.push_back(op_ret[pc]);
          exp_recv_dly.push_back(op_dly[pc]);
          exp_recv_nr.push_back(op_nr[pc]);
          if (op_nr[pc]) begin
            t += 1 + to_lp;
            exp_err = 1'b1;
            fin = 1'b1;
          end
          else begin
            t += 2 + op_dly[pc];
            exp_recv_acks++;
            if (op_ret[pc] != op_pay[pc]) begin
              exp_err = 1'b1;
              exp_mis++;
            end
            adv = 1'b1;
          end
        end
        3: begin t += 2 + int'(op_pay[pc][15:0]); adv = 1'b1; end
        4: begin t += 1; fin = 1'b1; end
        default: begin t += 1; exp_err = 1'b1; fin = 1'b1; end
      endcase
      if (adv) begin
        if (pc == rom_n_lp - 1) begin
          exp_err = 1'b1;
          fin = 1'b1;
        end
        else pc++;
      end
    end
    exp_pc = pc;
    exp_done_t = t;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    yumi    = 1'b0;
    v_i     = 1'b0;
    pkt_i   = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_trace(input string name);
    int t = 0, vcnt = 0, rcnt = 0, si = 0, ri = 0, vtot = 0, done_t = -1;
    int budget = exp_done_t + 40;
    logic [aw_lp-1:0] pc_at_done;
    do_reset();
    while (t < budget && done_t < 0) begin
      @(negedge clk);
      t++;
      yumi  = 1'b0;
      v_i   = 1'b0;
      pkt_i = rand_pay();
      if (v_o) begin
        vtot++;
        checks++;
        if (si >= exp_send.size()) begin
          errors++;
          $display("FAIL %s extra_send t=%0d got pkt %h, no packet expected", name, t, pkt_o);
        end
        else begin
          if (pkt_o !== exp_send[si]) begin
            errors++;
            $display("FAIL %s send_pkt t=%0d got %h want %h", name, t, pkt_o, exp_send[si]);
          end
          if (vcnt == exp_send_dly[si]) begin
            yumi = 1'b1; si++; vcnt = 0;
          end
          else vcnt++;
        end
      end
      else begin
        checks++;
        if (pkt_o !== '0) begin
          errors++;
          $display("FAIL %s pkt_idle t=%0d got %h want 0", name, t, pkt_o);
        end
        yumi = ($urandom_range(0, 3) == 0);
      end
      if (ready) begin
        checks++;
        if (v_o) begin
          errors++;
          $display("FAIL %s both_handshakes t=%0d got v_o=1 ready=1 want not both", name, t);
        end
        if (ri >= exp_recv_dly.size()) begin
          errors++;
          $display("FAIL %s extra_recv t=%0d got ready=1 want 0", name, t);
        end
        else if (!exp_recv_nr[ri]) begin
          if (rcnt == exp_recv_dly[ri]) begin
            v_i = 1'b1; pkt_i = exp_recv_val[ri]; ri++; rcnt = 0;
          end
          else rcnt++;
        end
      end
      else v_i = ($urandom_range(0, 3) == 0);
      if (done) done_t = t;
    end
    pc_at_done = rom_addr;
    checks++;
    if (done_t != exp_done_t) begin
      errors++;
      $display("FAIL %s done_time got %0d want %0d (-1 = never)", name, done_t, exp_done_t);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s error_o got %b want %b", name, err, exp_err);
    end
    checks++;
    if (mis !== 16'(exp_mis)) begin
      errors++;
      $display("FAIL %s mismatch_cnt got %0d want %0d", name, mis, exp_mis);
    end
    checks++;
    if (rom_addr !== aw_lp'(exp_pc)) begin
      errors++;
      $display("FAIL %s final_pc got %0d want %0d", name, rom_addr, exp_pc);
    end
    checks++;
    if (si != exp_send.size() || ri != exp_recv_acks || vtot != exp_vcyc) begin
      errors++;
      $display("FAIL %s handshake_counts got sends=%0d recvs=%0d vcyc=%0d want %0d %0d %0d",
               name, si, ri, vtot, exp_send.size(), exp_recv_acks, exp_vcyc);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      yumi = 1'b1; v_i = 1'b1; pkt_i = rand_pay();
      checks++;
      if (done !== 1'b1 || v_o !== 1'b0 || ready !== 1'b0 || rom_addr !== pc_at_done) begin
        errors++;
        $display("FAIL %s done_hold got done=%b v=%b rdy=%b pc=%0d want 1 0 0 %0d",
                 name, done, v_o, ready, rom_addr, pc_at_done);
      end
    end
    yumi = 1'b0; v_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_trace();
    set_op(0, 1, rand_pay(), 0, '0, 1'b0);
    load_rom();
    reset_n = 1'b0; en = 1'b0; yumi = 1'b0; v_i = 1'b0; pkt_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (v_o !== 1'b0 || ready !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        mis !== 16'd0 || rom_addr !== '0) begin
      errors++;
      $display("FAIL reset_values got v=%b rdy=%b done=%b err=%b mis=%0d pc=%0d want all 0",
               v_o, ready, done, err, mis, rom_addr);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (v_o !== 1'b0 || rom_addr !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got v=%b pc=%0d done=%b want 0 0 0", v_o, rom_addr, done);
    end
  endtask

  task automatic test_send_single();
    clear_trace();
    set_op(0, 1, 40'h12_3456_789A, 0, '0, 1'b0);
    load_rom(); build_expect();
    run_trace("send_single");
  endtask

  task automatic test_send_recv();
    logic [trw_lp-1:0] a = rand_pay();
    clear_trace();
    set_op(0, 1, a, 5, '0, 1'b0);
    set_op(1, 2, a, 3, a, 1'b0);
    load_rom(); build_expect();
    run_trace("send_recv");
  endtask

  task automatic test_mismatch();
    logic [trw_lp-1:0] b = rand_pay();
    clear_trace();
    set_op(0, 2, b, 1, b ^ 40'h1, 1'b0);
    load_rom(); build_expect();
    run_trace("mismatch");
  endtask

  task automatic test_wait();
    clear_trace();
    set_op(0, 3, (40'($urandom) << 16) | 40'd10, 0, '0, 1'b0);
    load_rom(); build_expect();
    run_trace("wait_10");
    clear_trace();
    set_op(0, 3, 40'd0, 0, '0, 1'b0);
    load_rom(); build_expect();
    run_trace("wait_0");
  endtask

  task automatic test_timeout();
    clear_trace();
    set_op(0, 2, rand_pay(), 0, '0, 1'b1);
    load_rom(); build_expect();
    run_trace("timeout");
  endtask

  task automatic test_illegal();
    clear_trace();
    set_op(0, 7, rand_pay(), 0, '0, 1'b0);
    load_rom(); build_expect();
    run_trace("illegal_7");
    clear_trace();
    set_op(0, 0, '0, 0, '0, 1'b0);
    set_op(1, $urandom_range(5, 15), rand_pay(), 0, '0, 1'b0);
    load_rom(); build_expect();
    run_trace("illegal_rand");
  endtask

  task automatic test_overflow();
    clear_trace();
    for (int i = 0; i < rom_n_lp - 1; i++) set_op(i, 0, '0, 0, '0, 1'b0);
    set_op(rom_n_lp - 1, 1, rand_pay(), 1, '0, 1'b0);
    load_rom(); build_expect();
    run_trace("pc_overflow");
  endtask

  task automatic test_back_to_back();
    logic [trw_lp-1:0] p;
    clear_trace();
    for (int i = 0; i < 4; i++) set_op(i, 1, rand_pay(), 0, '0, 1'b0);
    for (int i = 4; i < 6; i++) begin
      p = rand_pay();
      set_op(i, 2, p, 0, p, 1'b0);
    end
    load_rom(); build_expect();
    run_trace("back_to_back");
  endtask

  task automatic test_stall();
    int done_t = -1;
    clear_trace();
    set_op(0, 3, 40'd5, 0, '0, 1'b0);
    set_op(1, 0, '0, 0, '0, 1'b0);
    load_rom();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int t = 3; t <= 20; t++) @(negedge clk);
    checks++;
    if (rom_addr !== aw_lp'(1) || done !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got pc=%0d done=%b want 1 0", rom_addr, done);
    end
    en = 1'b1;
    for (int t = 21; t <= 30 && done_t < 0; t++) begin
      @(negedge clk);
      if (done) done_t = t;
    end
    checks++;
    if (done_t != 22) begin
      errors++;
      $display("FAIL stall_resume done_time got %0d want 22", done_t);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [trw_lp-1:0] a = rand_pay();
    logic [trw_lp-1:0] b = rand_pay();
    bit seen = 1'b0;
    clear_trace();
    set_op(0, 2, b, 0, b ^ 40'h1, 1'b0);
    set_op(1, 1, a, 0, '0, 1'b0);
    load_rom(); build_expect();
    do_reset();
    for (int t = 1; t <= 20 && !seen; t++) begin
      @(negedge clk);
      yumi = 1'b0; v_i = 1'b0;
      if (v_o) seen = 1'b1;
      else if (ready) begin
        v_i = 1'b1; pkt_i = b ^ 40'h1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_send_reach got v_o never high want high within 20 cycles");
    end
    @(negedge clk);
    checks++;
    if (v_o !== 1'b1 || pkt_o !== a || err !== 1'b1 || mis !== 16'd1) begin
      errors++;
      $display("FAIL mid_send_state got v=%b pkt=%h err=%b mis=%0d want 1 %h 1 1",
               v_o, pkt_o, err, mis, a);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (v_o !== 1'b0 || rom_addr !== '0 || err !== 1'b0 || mis !== 16'd0 ||
        done !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_send_reset got v=%b pc=%0d err=%b mis=%0d done=%b rdy=%b want all 0",
               v_o, rom_addr, err, mis, done, ready);
    end
    run_trace("reset_rerun");
  endtask

  task automatic test_random();
    int n, kind;
    logic [trw_lp-1:0] p;
    for (int it = 0; it < 30; it++) begin
      clear_trace();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 3);
        p = rand_pay();
        case (kind)
          0: set_op(i, 0, p, 0, '0, 1'b0);
          1: set_op(i, 1, p, $urandom_range(0, 4), '0, 1'b0);
          2: set_op(i, 2, p, $urandom_range(0, 4),
                    ($urandom_range(0, 9) < 3) ? (p ^ (40'h1 << $urandom_range(0, 39))) : p, 1'b0);
          default: set_op(i, 3, (p << 16) | 40'($urandom_range(0, 6)), 0, '0, 1'b0);
        endcase
      end
      case ($urandom_range(0, 7))
        0: set_op(n, $urandom_range(5, 15), rand_pay(), 0, '0, 1'b0);
        1: set_op(n, 2, rand_pay(), 0, '0, 1'b1);
        default: set_op(n, 4, rand_pay(), 0, '0, 1'b0);
      endcase
      load_rom(); build_expect();
      run_trace($sformatf("random_%0d", it));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_send_single();
    test_send_recv();
    test_mismatch();
    test_wait();
    test_timeout();
    test_illegal();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_reset_mid_send();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
